data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
// Multi-cycle data memory for the MIPS single-cycle core, directly downstream of the data path.
// Consumes alu_out (address), mem_write_data and the mem_read/mem_write controls.
// Returns mem_read_data and a stall that freezes PC/reg-file update until the access completes.
// Word-addressed internal RAM with a fixed programmable access latency.
// PARAMETERS
// DEPTH_LOG2  8   log2 of number of 32-bit words in RAM (index = addr[DEPTH_LOG2+1:2])
// LATENCY     2   cycles spent in ACCESS per transaction; legal range 1..15
// PORTS
// clk           in   1   clock, rising edge
// arst_n        in   1   asynchronous reset, active-low
// mem_read      in   1   load request from control unit
// mem_write     in   1   store request from control unit
// addr          in   32  byte address (alu_out)
// wdata         in   32  store data (mem_write_data)
// rdata         out  32  load data to data path mem_read_data; registered
// stall         out  1   high while transaction pending; data path must hold state
// done          out  1   one-cycle pulse, transaction complete
// misalign_err  out  1   sticky, set on request with addr[1:0]!=0
// BEHAVIOUR
// - Reset (async): state=IDLE, cnt=0, rdata=0, done=0, misalign_err=0; RAM contents not cleared.
// - req = mem_read | mem_write; mem_write has priority if both high (treated as store).
// - FSM states IDLE, ACCESS, DONE.
// - IDLE: req & addr[1:0]==0 -> latch index, wdata, op; cnt<=0; go ACCESS.
//   stall = combinational (IDLE & aligned req) | ACCESS, so stall rises in the request cycle.
// - IDLE: req & addr[1:0]!=0 -> misalign_err<=1; no access; stay IDLE; stall stays 0;
//   rdata unchanged.
// - ACCESS: cnt increments each cycle.
//   - At cnt==LATENCY-1: store writes latched wdata to RAM[index]; load registers RAM[index]
//     into rdata; go DONE.
//   - ACCESS lasts exactly LATENCY cycles.
// - DONE: done=1, stall=0 for exactly one cycle; inputs ignored; next state IDLE.
//   Data path commits at the end of this cycle.
// - Latency: request sampled in cycle T -> stall high T..T+LATENCY; done and valid rdata in
//   cycle T+LATENCY+1.
// - rdata holds the last load value until the next load completes; stores never alter rdata.
// - Addresses beyond RAM wrap: upper bits addr[31:DEPTH_LOG2+2] ignored.
// - Input changes during ACCESS have no effect; latched values are used.
// - Reset mid-transaction: aborts; a pending store is discarded (RAM untouched); returns IDLE.
// - misalign_err clears only on reset.
// TESTING (DEPTH_LOG2=8, LATENCY=2)
// - Store 0xDEADBEEF at addr 0x10, then load 0x10 -> stall high 3 cycles each;
//   load done cycle rdata=0xDEADBEEF.
// - Load addr 0x410 after the above -> wraps to word 4, rdata=0xDEADBEEF.
// - Request at addr 0x13 -> misalign_err=1 next cycle, stall never rises, rdata unchanged,
//   RAM[4] unchanged.
// - mem_read=mem_write=1, addr 0x20, wdata 0x12345678 -> RAM[8]=0x12345678, rdata unchanged.
// - Store 0xAAAA5555 to 0x30; assert arst_n=0 in 1st ACCESS cycle -> all outputs reset;
//   later load of 0x30 returns prior value.
// - Change addr/wdata mid-ACCESS (0x40->0x44) -> access uses 0x40; done pulses exactly once.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle word-addressed data memory for the MIPS core.
// Accepts one load or store at a time from the data path. Stall is asserted
// from the request cycle until the access completes. Done pulses for one
// cycle when the result is ready to commit.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    is_store_q;
  logic [31:0]             mem [2**DEPTH_LOG2];

  logic req, aligned, last_beat;

  assign req       = mem_read | mem_write;
  assign aligned   = (addr[1:0] == 2'b00);
  assign last_beat = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  // Upper address bits are deliberately dropped so addresses wrap in the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic plus stall/done decode; stall rises in the request cycle.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && aligned) begin
          state_d = ACCESS;
          stall   = 1'b1;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, beat counter and sticky misalignment flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      is_store_q   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (state_q == IDLE && req) begin
        if (aligned) begin
          idx_q      <= addr[DEPTH_LOG2+1:2];
          wdata_q    <= wdata;
          is_store_q <= mem_write;
          cnt_q      <= '0;
        end else begin
          misalign_err <= 1'b1;
        end
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // RAM write port; contents survive reset, and an aborted store never
  // reaches its last beat because reset forces the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (last_beat && is_store_q) mem[idx_q] <= wdata_q;
  end

  // Load data register; only completed loads update it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                      rdata <= '0;
    else if (last_beat && !is_store_q) rdata <= mem[idx_q];
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl
// (DEPTH_LOG2=8, LATENCY=2). Inputs change 1ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, misalign_err;

  int total = 0;
  int bad   = 0;

  data_mem_ctrl #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .done         (done),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One aligned transaction: request in cycle T, stall T..T+2, done at T+3.
  task automatic xact(input string tag, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    @(negedge clk);
    chk({tag, " stall T"}, 32'(stall), 32'd1);
    chk({tag, " done T"},  32'(done),  32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk({tag, " stall T+1"}, 32'(stall), 32'd1);
    chk({tag, " done T+1"},  32'(done),  32'd0);
    @(negedge clk);
    chk({tag, " stall T+2"}, 32'(stall), 32'd1);
    chk({tag, " done T+2"},  32'(done),  32'd0);
    @(negedge clk);
    chk({tag, " stall T+3"}, 32'(stall), 32'd0);
    chk({tag, " done T+3"},  32'(done),  32'd1);
    chk({tag, " rdata"},     rdata,      exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dones;
    arst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    #2;
    chk("reset rdata",    rdata,             32'h0);
    chk("reset stall",    32'(stall),        32'd0);
    chk("reset done",     32'(done),         32'd0);
    chk("reset misalign", 32'(misalign_err), 32'd0);
    #10 arst_n = 1'b1;

    // Basic store/load; stores leave rdata alone.
    xact("st 0x10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    xact("ld 0x10", 1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF);
    xact("st 0x14", 1'b0, 1'b1, 32'h14, 32'h11112222, 32'hDEADBEEF);
    xact("ld 0x14", 1'b1, 1'b0, 32'h14, 32'h0,        32'h11112222);
    // 0x410 wraps onto word 4.
    xact("ld 0x410", 1'b1, 1'b0, 32'h410, 32'h0, 32'hDEADBEEF);
    xact("ld 0x14b", 1'b1, 1'b0, 32'h14, 32'h0,  32'h11112222);

    // Misaligned store: flag only, no stall, no RAM access.
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h13; wdata = 32'h0BAD0BAD;
    @(negedge clk);
    chk("misal stall T", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(negedge clk);
    chk("misal flag",    32'(misalign_err), 32'd1);
    chk("misal stall",   32'(stall),        32'd0);
    chk("misal done",    32'(done),         32'd0);
    chk("misal rdata",   rdata,             32'h11112222);
    xact("ld 0x10 after misal", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    chk("misal sticky",  32'(misalign_err), 32'd1);

    // Both controls high acts as a store.
    xact("rw 0x20", 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF);
    xact("ld 0x20", 1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678);

    // Reset during the first ACCESS cycle discards the store.
    xact("st 0x30", 1'b0, 1'b1, 32'h30, 32'h0BADF00D, 32'h12345678);
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h30; wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    mem_write = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    chk("midrst rdata",    rdata,             32'h0);
    chk("midrst stall",    32'(stall),        32'd0);
    chk("midrst done",     32'(done),         32'd0);
    chk("midrst misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    xact("ld 0x30", 1'b1, 1'b0, 32'h30, 32'h0, 32'h0BADF00D);

    // Inputs changed during ACCESS are ignored.
    xact("st 0x44", 1'b0, 1'b1, 32'h44, 32'h44444444, 32'h0BADF00D);
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h40; wdata = 32'hCAFE0040;
    @(negedge clk);
    chk("chg stall T", 32'(stall), 32'd1);
    dones = 0;
    @(posedge clk); #1;
    addr = 32'h44; wdata = 32'hFFFF0044;
    @(negedge clk);
    dones += int'(done);
    @(posedge clk); #1;
    mem_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("chg done count", 32'(dones), 32'd1);
    xact("ld 0x40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE0040);
    xact("ld 0x44", 1'b1, 1'b0, 32'h44, 32'h0, 32'h44444444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
